dpc_judge_param: RTL and testbench

DPC_JUDGE_PARAM -- requirements
Module: dpc_judge_param

---
 rtl/dpc_judge_param.sv | 186 ++++++++++++++++++
 tb/tb_dpc_judge_param.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dpc_judge_param.sv
// Defective-pixel judge: flags a centre pixel whose eight neighbours agree in
// sign and enough of them exceed a magnitude threshold, substitutes the
// replacement value, and counts flagged pixels per frame.
module dpc_judge_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_enable,
    input  logic [DATA_W-1:0]         i_dpc_threshold,
    input  logic [3:0]                i_min_hits,
    input  logic                      i_line_vaild,
    input  logic                      i_frame_start,
    input  logic [3*(DATA_W+1)-1:0]   i_line3_1,
    input  logic [3*(DATA_W+1)-1:0]   i_line3_2,
    input  logic [3*(DATA_W+1)-1:0]   i_line3_3,
    input  logic [DATA_W-1:0]         i_mid_num,
    output logic [DATA_W-1:0]         o_judge_data,
    output logic                      o_judge_vaild,
    output logic                      o_judge_flag,
    output logic [CNT_W-1:0]          o_defect_cnt,
    output logic                      o_cnt_sat
);

    localparam int unsigned EL_W  = DATA_W + 1;
    localparam int unsigned WIN_W = 9 * EL_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // stage 0 registers
    logic [WIN_W-1:0]  s0_win_d, s0_win_q;
    logic [DATA_W-1:0] s0_mid_d, s0_mid_q;
    logic [DATA_W-1:0] s0_thr_d, s0_thr_q;
    logic [3:0]        s0_minh_d, s0_minh_q;
    logic              s0_vld_d, s0_vld_q;
    logic              s0_fs_d, s0_fs_q;
    logic              s0_en_d, s0_en_q;

    // stage 1 registers
    logic [DATA_W-1:0] s1_mag_d [8];
    logic [DATA_W-1:0] s1_mag_q [8];
    logic              s1_agree_d, s1_agree_q;
    logic [DATA_W-1:0] s1_ctr_d, s1_ctr_q;
    logic [DATA_W-1:0] s1_mid_d, s1_mid_q;
    logic [DATA_W-1:0] s1_thr_d, s1_thr_q;
    logic [3:0]        s1_minh_d, s1_minh_q;
    logic              s1_vld_d, s1_vld_q;
    logic              s1_fs_d, s1_fs_q;
    logic              s1_en_d, s1_en_q;

    // output stage and frame counter
    logic [DATA_W-1:0] data_d, data_q;
    logic              vld_d, vld_q;
    logic              flag_d, flag_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              sat_d, sat_q;
    logic [CNT_W-1:0]  dcnt_d, dcnt_q;
    logic              osat_d, osat_q;

    logic [EL_W-1:0]   el [9];
    logic [7:0]        sign;
    logic [3:0]        hits;
    logic              flag_raw;
    logic              count_now;

    // Stage 0: capture the window and its controls as presented
    always_comb begin
        s0_win_d  = {i_line3_1, i_line3_2, i_line3_3};
        s0_mid_d  = i_mid_num;
        s0_thr_d  = i_dpc_threshold;
        s0_minh_d = i_min_hits;
        s0_vld_d  = i_line_vaild;
        s0_fs_d   = i_frame_start;
        s0_en_d   = i_enable;
    end

    // Stage 1: neighbour magnitudes, sign agreement, clamped min_hits
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            el[k] = s0_win_q[(9-k)*EL_W-1 -: EL_W];
        end
        for (int j = 0; j < 8; j++) begin
            sign[j]     = el[(j < 4) ? j : j + 1][DATA_W];
            s1_mag_d[j] = sign[j] ? ~el[(j < 4) ? j : j + 1][DATA_W-1:0]
                                  :  el[(j < 4) ? j : j + 1][DATA_W-1:0];
        end
        s1_agree_d = (&sign) | ~(|sign);
        s1_ctr_d   = el[4][DATA_W-1:0];
        s1_mid_d   = s0_mid_q;
        s1_thr_d   = s0_thr_q;
        if (s0_minh_q == 4'd0)      s1_minh_d = 4'd1;
        else if (s0_minh_q > 4'd8)  s1_minh_d = 4'd8;
        else                        s1_minh_d = s0_minh_q;
        s1_vld_d   = s0_vld_q;
        s1_fs_d    = s0_fs_q;
        s1_en_d    = s0_en_q;
    end

    // Stage 2: hit count, decision, output mux and per-frame counting
    always_comb begin
        hits = 4'd0;
        for (int j = 0; j < 8; j++) begin
            hits = hits + 4'(s1_mag_q[j] > s1_thr_q);
        end
        flag_raw  = s1_en_q & s1_agree_q & (hits >= s1_minh_q);
        count_now = s1_vld_q & flag_raw;
        data_d    = flag_raw ? s1_mid_q : s1_ctr_q;
        vld_d     = s1_vld_q;
        flag_d    = count_now;

        cnt_d  = cnt_q;
        sat_d  = sat_q;
        dcnt_d = dcnt_q;
        osat_d = osat_q;
        if (s1_fs_q) begin
            // pixel coincident with frame start opens the new frame
            dcnt_d = cnt_q;
            osat_d = sat_q;
            cnt_d  = CNT_W'(count_now);
            sat_d  = 1'b0;
        end else if (count_now) begin
            if (cnt_q == CNT_MAX) sat_d = 1'b1;
            else                  cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pipeline and counter state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_win_q   <= '0;
            s0_mid_q   <= '0;
            s0_thr_q   <= '0;
            s0_minh_q  <= '0;
            s0_vld_q   <= 1'b0;
            s0_fs_q    <= 1'b0;
            s0_en_q    <= 1'b0;
            for (int j = 0; j < 8; j++) s1_mag_q[j] <= '0;
            s1_agree_q <= 1'b0;
            s1_ctr_q   <= '0;
            s1_mid_q   <= '0;
            s1_thr_q   <= '0;
            s1_minh_q  <= '0;
            s1_vld_q   <= 1'b0;
            s1_fs_q    <= 1'b0;
            s1_en_q    <= 1'b0;
            data_q     <= '0;
            vld_q      <= 1'b0;
            flag_q     <= 1'b0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            dcnt_q     <= '0;
            osat_q     <= 1'b0;
        end else begin
            s0_win_q   <= s0_win_d;
            s0_mid_q   <= s0_mid_d;
            s0_thr_q   <= s0_thr_d;
            s0_minh_q  <= s0_minh_d;
            s0_vld_q   <= s0_vld_d;
            s0_fs_q    <= s0_fs_d;
            s0_en_q    <= s0_en_d;
            for (int j = 0; j < 8; j++) s1_mag_q[j] <= s1_mag_d[j];
            s1_agree_q <= s1_agree_d;
            s1_ctr_q   <= s1_ctr_d;
            s1_mid_q   <= s1_mid_d;
            s1_thr_q   <= s1_thr_d;
            s1_minh_q  <= s1_minh_d;
            s1_vld_q   <= s1_vld_d;
            s1_fs_q    <= s1_fs_d;
            s1_en_q    <= s1_en_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
            flag_q     <= flag_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            dcnt_q     <= dcnt_d;
            osat_q     <= osat_d;
        end
    end

    assign o_judge_data  = data_q;
    assign o_judge_vaild = vld_q;
    assign o_judge_flag  = flag_q;
    assign o_defect_cnt  = dcnt_q;
    assign o_cnt_sat     = osat_q;

endmodule

// File: tb/tb_dpc_judge_param.sv
// Directed table plus hand sequences for dpc_judge_param (DATA_W=8, CNT_W=4).
module tb_dpc_judge_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_enable;
    logic [7:0]  i_dpc_threshold;
    logic [3:0]  i_min_hits;
    logic        i_line_vaild;
    logic        i_frame_start;
    logic [26:0] i_line3_1, i_line3_2, i_line3_3;
    logic [7:0]  i_mid_num;
    logic [7:0]  o_judge_data;
    logic        o_judge_vaild;
    logic        o_judge_flag;
    logic [3:0]  o_defect_cnt;
    logic        o_cnt_sat;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    dpc_judge_param #(.DATA_W(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .i_enable(i_enable),
        .i_dpc_threshold(i_dpc_threshold), .i_min_hits(i_min_hits),
        .i_line_vaild(i_line_vaild), .i_frame_start(i_frame_start),
        .i_line3_1(i_line3_1), .i_line3_2(i_line3_2), .i_line3_3(i_line3_3),
        .i_mid_num(i_mid_num), .o_judge_data(o_judge_data),
        .o_judge_vaild(o_judge_vaild), .o_judge_flag(o_judge_flag),
        .o_defect_cnt(o_defect_cnt), .o_cnt_sat(o_cnt_sat)
    );

    typedef struct {
        logic [8:0][8:0] p;
        logic [7:0]      mid;
        logic [7:0]      thr;
        logic [3:0]      minh;
        logic            en;
        logic [7:0]      ed;
        logic            ef;
    } vec_t;

    vec_t tbl [12];

    function automatic vec_t mk(input logic [8:0] nb, input logic [8:0] c,
                                input logic [7:0] mid, input logic [7:0] thr,
                                input logic [3:0] minh, input logic en,
                                input logic [7:0] ed, input logic ef);
        vec_t v;
        for (int k = 0; k < 9; k++) v.p[k] = nb;
        v.p[4] = c;
        v.mid = mid; v.thr = thr; v.minh = minh; v.en = en;
        v.ed = ed; v.ef = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic vld, input logic fs);
        i_line3_1       = {v.p[0], v.p[1], v.p[2]};
        i_line3_2       = {v.p[3], v.p[4], v.p[5]};
        i_line3_3       = {v.p[6], v.p[7], v.p[8]};
        i_mid_num       = v.mid;
        i_dpc_threshold = v.thr;
        i_min_hits      = v.minh;
        i_enable        = v.en;
        i_line_vaild    = vld;
        i_frame_start   = fs;
    endtask

    // present one cycle of input, then idle until its output-stage cycle
    task automatic launch(input vec_t v, input logic vld, input logic fs);
        @(negedge clk) drive(v, vld, fs);
        @(posedge clk);
        @(negedge clk) begin i_line_vaild = 1'b0; i_frame_start = 1'b0; end
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"}, 32'(o_judge_data), 32'h0);
        check({tag, "_vaild"}, 32'(o_judge_vaild), 32'h0);
        check({tag, "_flag"}, 32'(o_judge_flag), 32'h0);
        check({tag, "_cnt"}, 32'(o_defect_cnt), 32'h0);
        check({tag, "_sat"}, 32'(o_cnt_sat), 32'h0);
    endtask

    initial begin
        vec_t v0;
        int   nflag;

        v0 = mk(9'h040, 9'h0FF, 8'h30, 8'h20, 4'd8, 1'b1, 8'h30, 1'b1);
        tbl[0]  = v0;
        tbl[1]  = v0; tbl[1].p[8] = 9'h140; tbl[1].ed = 8'hFF; tbl[1].ef = 1'b0;
        tbl[2]  = v0; tbl[2].p[0] = 9'h010; tbl[2].p[1] = 9'h010; tbl[2].minh = 4'd6;
        tbl[3]  = tbl[2]; tbl[3].minh = 4'd7;  tbl[3].ed = 8'hFF; tbl[3].ef = 1'b0;
        tbl[4]  = tbl[2]; tbl[4].minh = 4'd0;
        tbl[5]  = tbl[2]; tbl[5].minh = 4'd15; tbl[5].ed = 8'hFF; tbl[5].ef = 1'b0;
        tbl[6]  = mk(9'h010, 9'h0FF, 8'h30, 8'h20, 4'd0, 1'b1, 8'hFF, 1'b0);
        tbl[7]  = v0; tbl[7].minh = 4'd15;
        tbl[8]  = mk(9'h19F, 9'h0FF, 8'h30, 8'h60, 4'd8, 1'b1, 8'hFF, 1'b0);
        tbl[9]  = tbl[8]; tbl[9].thr = 8'h5F; tbl[9].ed = 8'h30; tbl[9].ef = 1'b1;
        tbl[10] = v0; tbl[10].en = 1'b0; tbl[10].ed = 8'hFF; tbl[10].ef = 1'b0;
        tbl[11] = mk(9'h040, 9'h1AB, 8'h30, 8'hFF, 4'd1, 1'b1, 8'hAB, 1'b0);

        reset = 1'b1;
        drive(v0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        @(negedge clk) reset = 1'b0;

        // table: each window alone, checked at its output cycle
        nflag = 0;
        for (int i = 0; i < 12; i++) begin
            launch(tbl[i], 1'b1, 1'b0);
            check($sformatf("v%0d_data", i), 32'(o_judge_data), 32'(tbl[i].ed));
            check($sformatf("v%0d_flag", i), 32'(o_judge_flag), 32'(tbl[i].ef));
            check($sformatf("v%0d_vaild", i), 32'(o_judge_vaild), 32'h1);
            if (tbl[i].ef) nflag++;
        end

        // frame start closes the table frame
        launch(v0, 1'b0, 1'b1);
        check("frame1_cnt", 32'(o_defect_cnt), 32'(nflag));
        check("frame1_sat", 32'(o_cnt_sat), 32'h0);

        // flag is masked while valid is low, data still computed
        launch(v0, 1'b0, 1'b0);
        check("novld_data", 32'(o_judge_data), 32'h30);
        check("novld_flag", 32'(o_judge_flag), 32'h0);
        check("novld_vaild", 32'(o_judge_vaild), 32'h0);

        // 20 flagged pixels saturate a 4-bit counter
        for (int i = 0; i < 20; i++) @(negedge clk) drive(v0, 1'b1, 1'b0);
        launch(v0, 1'b0, 1'b1);
        check("sat_cnt", 32'(o_defect_cnt), 32'hF);
        check("sat_sat", 32'(o_cnt_sat), 32'h1);

        // flagged pixel together with frame start belongs to the new frame
        launch(v0, 1'b1, 1'b1);
        check("coinc_cnt", 32'(o_defect_cnt), 32'h0);
        check("coinc_sat", 32'(o_cnt_sat), 32'h0);
        check("coinc_flag", 32'(o_judge_flag), 32'h1);
        launch(v0, 1'b0, 1'b1);
        check("next_cnt", 32'(o_defect_cnt), 32'h1);
        check("next_sat", 32'(o_cnt_sat), 32'h0);

        // reset in the middle of a streaming frame
        for (int i = 0; i < 6; i++) @(negedge clk) drive(v0, 1'b1, 1'b0);
        @(negedge clk) reset = 1'b1;
        #1 check_outputs_zero("midrst");
        @(posedge clk);
        #1 check_outputs_zero("midrst_hold");
        @(negedge clk) begin
            reset = 1'b0;
            drive(tbl[10], 1'b1, 1'b0);
        end
        @(posedge clk);
        @(negedge clk) i_line_vaild = 1'b0;
        @(posedge clk);
        #1 check("restart_early_vaild", 32'(o_judge_vaild), 32'h0);
        @(posedge clk);
        #1;
        check("restart_vaild", 32'(o_judge_vaild), 32'h1);
        check("restart_data", 32'(o_judge_data), 32'hFF);
        check("restart_flag", 32'(o_judge_flag), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
